// File: rtl/spi_byte_stream_if.sv
// Byte-stream side and spi_master_m side signals of spi_byte_stream.
// The slave modport is the block's view; master is the surrounding logic's view.
interface spi_byte_stream_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       m_start;
  logic       m_busy;
  logic [7:0] m_dout;
  logic [7:0] m_din;
  logic       active;
  logic       err;

  modport slave (
    input  tx_data, tx_valid, rx_ready, m_busy, m_din,
    output tx_ready, rx_data, rx_valid, m_start, m_dout, active, err
  );

  modport master (
    output tx_data, tx_valid, rx_ready, m_busy, m_din,
    input  tx_ready, rx_data, rx_valid, m_start, m_dout, active, err
  );
endinterface

// File: rtl/spi_byte_stream.sv
// Byte-stream front end for spi_master_m: TX FIFO feeds one START/BUSY transfer
// per byte, and each received byte lands in a first-word fall-through RX FIFO.
module spi_byte_stream #(
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  spi_byte_stream_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE
  } state_t;

  localparam int            CW         = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] TO_ONE     = CW'(1);
  // The LAUNCH cycle counts as the first of the BUSY_TIMEOUT cycles, so ERR is
  // visible exactly BUSY_TIMEOUT cycles after the M_START pulse.
  localparam logic [CW-1:0] TO_LAST    = CW'(BUSY_TIMEOUT - 2);

  state_t state_reg, state_next;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [AW:0]   tx_count_reg;
  logic          tx_push, tx_pop;

  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [AW:0]   rx_count_reg;
  logic          rx_push, rx_pop;

  logic [CW-1:0] to_cnt_reg;
  logic          to_clear, to_inc, err_set;
  logic          m_start_reg, err_reg;
  logic [7:0]    m_dout_reg;
  logic          launch_ok;

  // ---------------- TX FIFO ----------------
  assign bus.tx_ready = (tx_count_reg < FULL_COUNT);
  assign tx_push      = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count_reg <= tx_count_reg + CNT_ONE;
        2'b01:   tx_count_reg <= tx_count_reg - CNT_ONE;
        default: tx_count_reg <= tx_count_reg;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  assign bus.rx_valid = (rx_count_reg != '0);
  assign bus.rx_data  = rx_mem[rx_rd_ptr_reg];
  assign rx_pop       = bus.rx_valid && bus.rx_ready;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= bus.m_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + CNT_ONE;
        2'b01:   rx_count_reg <= rx_count_reg - CNT_ONE;
        default: rx_count_reg <= rx_count_reg;
      endcase
    end
  end

  // ---------------- Transfer sequencer ----------------
  // Reserving an RX slot before launching means CAPTURE can never overflow.
  assign launch_ok = (tx_count_reg != '0) && (rx_count_reg < FULL_COUNT) && !bus.m_busy;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (launch_ok) state_next = S_LAUNCH;
      S_LAUNCH:    state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.m_busy)                state_next = S_WAIT_DONE;
        else if (to_cnt_reg == TO_LAST) state_next = S_IDLE;
      end
      S_WAIT_DONE: if (!bus.m_busy) state_next = S_CAPTURE;
      S_CAPTURE:   state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    to_clear = 1'b0;
    to_inc   = 1'b0;
    err_set  = 1'b0;
    case (state_reg)
      S_IDLE:      tx_pop = launch_ok;
      S_LAUNCH:    to_clear = 1'b1;
      S_WAIT_BUSY: begin
        if (!bus.m_busy) begin
          if (to_cnt_reg == TO_LAST) err_set = 1'b1;
          else                       to_inc  = 1'b1;
        end
      end
      S_CAPTURE:   rx_push = 1'b1;
      default:     ;
    endcase
  end

  assign bus.active = (state_reg != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg  <= '0;
      m_start_reg <= 1'b0;
      m_dout_reg  <= 8'h00;
      err_reg     <= 1'b0;
    end else begin
      if (to_clear)    to_cnt_reg <= '0;
      else if (to_inc) to_cnt_reg <= to_cnt_reg + TO_ONE;
      m_start_reg <= (state_next == S_LAUNCH);
      // DOUT only moves on a launch, so it is stable for the whole transfer.
      if (tx_pop) m_dout_reg <= tx_mem[tx_rd_ptr_reg];
      if (err_set) err_reg <= 1'b1;
    end
  end

  assign bus.m_start = m_start_reg;
  assign bus.m_dout  = m_dout_reg;
  assign bus.err     = err_reg;

endmodule
